muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit owning the HI/LO architectural registers.
//  Sits in EX beside ALU32Bit and replaces the single-cycle HiLoReg path.
//  Executes MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U)/MTHI/MTLO. Exposes Busy/Stall to HazardDetection so MFHI/MFLO and back-to-back ops wait.
// PARAMETERS
//  WIDTH       32  operand and HI/LO width (even, >=8)
//  MUL_CYCLES  3   multiply latency in cycles, 1..8 (product pipelined through MUL_CYCLES stages)
// PORTS
//  Clk       in   1      clock, rising edge
//  Rst       in   1      asynchronous, active-low reset
//  Start     in   1      issue Op this cycle (EX stage, already stall-qualified)
//  Op        in   4      0:MULT 1:MULTU 2:DIV 3:DIVU 4:MADD 5:MADDU 6:MSUB 7:MSUBU 8:MTHI 9:MTLO, others no-op
//  SrcA      in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  SrcB      in   WIDTH  rt operand (divisor / multiplier)
//  Flush     in   1      abort in-flight op (branch/exception squash)
//  HiLoRead  in   1      ID-stage instruction is MFHI/MFLO
//  Busy      out  1      operation in flight
//  Done      out  1      one-cycle pulse: HI/LO just updated by mul/div
//  Stall     out  1      Busy & (HiLoRead | Start), combinational
//  Hi        out  WIDTH  HI register
//  Lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (Rst=0, any time incl. mid-op): Hi=Lo=0, Busy=0, Done=0, FSM=IDLE, counters/partials cleared.
//  FSM: IDLE, MUL, DIV, DFIX. Start honoured only in IDLE; Start while Busy ignored (Stall=1 makes hazard logic hold it).
//  MTHI/MTLO: in IDLE, Hi (resp. Lo) <= SrcA at the Start edge; no Busy, no Done.
//  MUL path (ops 0,1,4-7): IDLE->MUL at Start edge; Busy=1 for MUL_CYCLES cycles;
//   at the edge ending the last MUL cycle {Hi,Lo} <= result, FSM->IDLE; Done=1 the following cycle (new Hi/Lo visible same cycle).
//   Product 2*WIDTH bits; signed ops sign-extend operands, unsigned zero-extend.
//   MADD: {Hi,Lo}+prod; MSUB: {Hi,Lo}-prod; modulo 2^(2*WIDTH), wrap silently. {Hi,Lo} sampled at commit.
//  DIV path (ops 2,3): restoring radix-2 on magnitudes; DIV state WIDTH cycles, then DFIX 1 cycle for sign correction
//   -> Busy WIDTH+1 cycles, commit at end of DFIX, Done next cycle. Lo=quotient, Hi=remainder.
//   Signed: quotient sign = sA^sB, remainder sign = sA (truncation toward zero).
//   Signed overflow (-2^(WIDTH-1) / -1): Lo=-2^(WIDTH-1), Hi=0.
//   Divide by zero: detected at Start; 1 busy cycle; Hi=SrcA, Lo=all ones; Done next cycle.
//  Operands latched at Start edge; SrcA/SrcB changes afterwards have no effect.
//  Flush: in any busy state -> IDLE at next edge, Hi/Lo unchanged, no Done. Flush with Start in IDLE: Start dropped.
//   Flush in the same cycle as commit edge: commit suppressed.
//  Start the cycle after a commit (Done=1 cycle) is legal; FSM is IDLE then.
//  Busy is registered (no comb path Start->Busy); Stall is combinational from Busy, HiLoRead, Start.
// TESTING (WIDTH=32, MUL_CYCLES=3)
//  1 MULT SrcA=-3 SrcB=7 -> Busy 3 cycles, Hi=FFFFFFFF Lo=FFFFFFEB, single Done pulse.
//  2 DIV SrcA=-7 SrcB=2 -> Busy 33 cycles, Lo=FFFFFFFD Hi=FFFFFFFF; DIVU 100/0 -> 1 cycle, Hi=00000064 Lo=FFFFFFFF.
//  3 MTLO FFFFFFFF, MTHI 0, MADDU 1*1 -> Hi=00000001 Lo=00000000; then MSUB 1*1 -> Hi=0 Lo=FFFFFFFF.
//  4 DIV 0x80000000 / FFFFFFFF -> Lo=80000000 Hi=0; DIVU same operands -> Lo=0 Hi=80000000.
//  5 Start DIV, Flush at busy cycle 10 -> Busy=0 next cycle, Hi/Lo unchanged, no Done; HiLoRead during busy -> Stall=1.
//  6 Rst=0 mid-MUL -> Hi=Lo=0, Busy=Done=0 immediately (async); after release, MTHI 5 -> Hi=5.

Source files
------------

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Multiplies are pipelined over MUL_CYCLES. Divides use radix-2 restoring steps on magnitudes, then a sign-fix cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic [W2-1:0]    pipe_q [MUL_CYCLES];
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;

  logic             is_mul_s;
  logic             is_div_s;
  logic             signed_s;
  logic [W2-1:0]    a_ext_s;
  logic [W2-1:0]    b_ext_s;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             b_zero_s;
  logic [WIDTH:0]   trial_s;
  logic             take_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [W2-1:0]    hilo_mul_d;

  // Decode the issued opcode into operation class and signedness.
  always_comb begin
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    signed_s = 1'b0;
    case (Op)
      OP_MULT, OP_MADD, OP_MSUB: begin
        is_mul_s = 1'b1;
        signed_s = 1'b1;
      end
      OP_MULTU, OP_MADDU, OP_MSUBU: is_mul_s = 1'b1;
      OP_DIV: begin
        is_div_s = 1'b1;
        signed_s = 1'b1;
      end
      OP_DIVU: is_div_s = 1'b1;
      default: is_mul_s = 1'b0;
    endcase
  end

  // A 2W x 2W product truncated to 2W is exact for both sign- and zero-extended operands.
  assign a_ext_s  = signed_s ? {{WIDTH{SrcA[WIDTH-1]}}, SrcA} : {{WIDTH{1'b0}}, SrcA};
  assign b_ext_s  = signed_s ? {{WIDTH{SrcB[WIDTH-1]}}, SrcB} : {{WIDTH{1'b0}}, SrcB};
  assign prod_s   = a_ext_s * b_ext_s;
  assign mag_a_s  = (signed_s && SrcA[WIDTH-1]) ? neg_w(SrcA) : SrcA;
  assign mag_b_s  = (signed_s && SrcB[WIDTH-1]) ? neg_w(SrcB) : SrcB;
  assign b_zero_s = (SrcB == {WIDTH{1'b0}});

  // The dividend shifts out of quo_q's MSB while quotient bits shift in at its LSB.
  assign trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign take_s  = ~trial_s[WIDTH];
  assign rem_d   = take_s ? trial_s[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_d   = {quo_q[WIDTH-2:0], take_s};

  // The overflow case -2^(W-1)/-1 falls out naturally: magnitude 2^(W-1), positive sign, same bits.
  assign quo_fix_s = neg_quo_q ? neg_w(quo_q) : quo_q;
  assign rem_fix_s = neg_rem_q ? neg_w(rem_q) : rem_q;

  // Multiply commit value; accumulate forms read {Hi,Lo} as it stands at commit.
  always_comb begin
    hilo_mul_d = pipe_q[MUL_CYCLES-1];
    case (op_q)
      OP_MADD, OP_MADDU: hilo_mul_d = {hi_q, lo_q} + pipe_q[MUL_CYCLES-1];
      OP_MSUB, OP_MSUBU: hilo_mul_d = {hi_q, lo_q} - pipe_q[MUL_CYCLES-1];
      default:           hilo_mul_d = pipe_q[MUL_CYCLES-1];
    endcase
  end

  // Control FSM together with HI/LO, operand latches and divider datapath.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      op_q      <= 4'd0;
      a_raw_q   <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      for (int i = 0; i < MUL_CYCLES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start && !Flush) begin
            if (is_mul_s) begin
              pipe_q[0] <= prod_s;
              op_q      <= Op;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_MUL;
            end else if (is_div_s) begin
              a_raw_q   <= SrcA;
              dvs_q     <= mag_b_s;
              rem_q     <= '0;
              quo_q     <= mag_a_s;
              neg_quo_q <= signed_s & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
              neg_rem_q <= signed_s & SrcA[WIDTH-1];
              dz_q      <= b_zero_s;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= b_zero_s ? S_DFIX : S_DIV;
            end else if (Op == OP_MTHI) begin
              hi_q <= SrcA;
            end else if (Op == OP_MTLO) begin
              lo_q <= SrcA;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          for (int i = 1; i < MUL_CYCLES; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
          if (Flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == MUL_LAST) begin
            {hi_q, lo_q} <= hilo_mul_d;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        S_DIV: begin
          if (Flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_q + ONE_C;
            state_q <= (cnt_q == DIV_LAST) ? S_DFIX : S_DIV;
          end
        end
        S_DFIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (Flush) begin
            done_q <= 1'b0;
          end else if (dz_q) begin
            hi_q   <= a_raw_q;
            lo_q   <= '1;
            done_q <= 1'b1;
          end else begin
            hi_q   <= rem_fix_s;
            lo_q   <= quo_fix_s;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Stall = busy_q & (HiLoRead | Start);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic model of HI/LO.
module tb_muldiv_hilo_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Op = 4'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        Flush = 1'b0;
  logic        HiLoRead = 1'b0;
  logic        Busy, Done, Stall;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  muldiv_hilo_unit #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .HiLoRead(HiLoRead), .Busy(Busy), .Done(Done), .Stall(Stall),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected HI/LO and busy length straight from the instruction definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    logic [63:0] acc, p;
    int sa, sb;
    sa  = $signed(a);
    sb  = $signed(b);
    acc = {m_hi, m_lo};
    hi  = m_hi;
    lo  = m_lo;
    lat = 0;
    if (op <= 4'd7 && op != 4'd2 && op != 4'd3) begin
      if (op == 4'd0 || op == 4'd4 || op == 4'd6) p = longint'(sa) * longint'(sb);
      else p = {32'd0, a} * {32'd0, b};
      if (op == 4'd4 || op == 4'd5) acc = acc + p;
      else if (op == 4'd6 || op == 4'd7) acc = acc - p;
      else acc = p;
      {hi, lo} = acc;
      lat = 3;
    end else if (op == 4'd2 || op == 4'd3) begin
      lat = 33;
      if (b == 32'd0) begin
        hi = a; lo = 32'hFFFFFFFF; lat = 1;
      end else if (op == 4'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        lo = 32'h80000000; hi = 32'd0;
      end else if (op == 4'd2) begin
        lo = sa / sb; hi = sa % sb;
      end else begin
        lo = a / b; hi = a % b;
      end
    end else if (op == 4'd8) begin
      hi = a;
    end else if (op == 4'd9) begin
      lo = a;
    end
  endfunction

  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int elat, input string nm);
    int n;
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    tick();
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({nm, " busy_cycles"}, 64'(n), 64'(elat));
    check({nm, " done"}, {63'd0, Done}, {63'd0, (elat > 0)});
    check({nm, " hi"}, {32'd0, Hi}, {32'd0, ehi});
    check({nm, " lo"}, {32'd0, Lo}, {32'd0, elo});
    tick();
    check({nm, " done_drop"}, {63'd0, Done}, 64'd0);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic [3:0]  rop;
    int elat;

    vecs.push_back('{4'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 3});
    vecs.push_back('{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    vecs.push_back('{4'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1});
    vecs.push_back('{4'd9, 32'hFFFFFFFF, 32'd0,        32'h00000064, 32'hFFFFFFFF, 0});
    vecs.push_back('{4'd8, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 0});
    vecs.push_back('{4'd5, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 3});
    vecs.push_back('{4'd6, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 3});
    vecs.push_back('{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
    vecs.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33});
    vecs.push_back('{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3});
    vecs.push_back('{4'd12, 32'h1234,    32'h5678,     32'hFFFFFFFE, 32'h00000001, 0});
    vecs.push_back('{4'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33});
    vecs.push_back('{4'd7, 32'd2,        32'd3,        32'h00000001, 32'hFFFFFFF7, 3});
    vecs.push_back('{4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF8, 3});

    #3;
    check("reset busy", {63'd0, Busy}, 64'd0);
    check("reset done", {63'd0, Done}, 64'd0);
    check("reset hi", {32'd0, Hi}, 64'd0);
    check("reset lo", {32'd0, Lo}, 64'd0);
    #4 Rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Flush mid-divide, with Stall probed while busy.
    Op = 4'd2; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    HiLoRead = 1'b1; #1;
    check("stall hiloread", {63'd0, Stall}, 64'd1);
    HiLoRead = 1'b0; #1;
    check("stall quiet", {63'd0, Stall}, 64'd0);
    repeat (9) tick();
    check("flush busy before", {63'd0, Busy}, 64'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush busy", {63'd0, Busy}, 64'd0);
    check("flush done", {63'd0, Done}, 64'd0);
    check("flush hi", {32'd0, Hi}, {32'd0, m_hi});
    check("flush lo", {32'd0, Lo}, {32'd0, m_lo});
    tick();
    check("flush done later", {63'd0, Done}, 64'd0);

    // Flush coinciding with the multiply commit edge.
    Op = 4'd0; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (2) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flushc busy", {63'd0, Busy}, 64'd0);
    check("flushc done", {63'd0, Done}, 64'd0);
    check("flushc hi", {32'd0, Hi}, {32'd0, m_hi});
    check("flushc lo", {32'd0, Lo}, {32'd0, m_lo});

    // Flush together with Start in IDLE drops the Start.
    Op = 4'd8; SrcA = 32'h1234; Start = 1'b1; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    check("flushidle hi", {32'd0, Hi}, {32'd0, m_hi});
    check("flushidle busy", {63'd0, Busy}, 64'd0);

    // Start while busy is ignored and raises Stall.
    Op = 4'd1; SrcA = 32'd2; SrcB = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Op = 4'd8; SrcA = 32'hDEADBEEF; Start = 1'b1; #1;
    check("stall start", {63'd0, Stall}, 64'd1);
    tick();
    Start = 1'b0;
    tick();
    check("ignore done", {63'd0, Done}, 64'd1);
    check("ignore hi", {32'd0, Hi}, 64'd0);
    check("ignore lo", {32'd0, Lo}, 64'd6);

    // Back-to-back issue in the Done cycle.
    Op = 4'd0; SrcA = 32'd2; SrcB = 32'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    check("b2b first done", {63'd0, Done}, 64'd1);
    check("b2b first lo", {32'd0, Lo}, 64'd4);
    Op = 4'd1; SrcA = 32'd3; SrcB = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("b2b busy", {63'd0, Busy}, 64'd1);
    repeat (3) tick();
    check("b2b done", {63'd0, Done}, 64'd1);
    check("b2b hi", {32'd0, Hi}, 64'd0);
    check("b2b lo", {32'd0, Lo}, 64'd9);
    tick();
    m_hi = 32'd0; m_lo = 32'd9;

    // Random operations against the model.
    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, ehi, elo, elat);
      apply(rop, ra, rb, ehi, elo, elat, $sformatf("rand%0d op%0d", k, rop));
    end

    // Asynchronous reset mid-multiply.
    Op = 4'd0; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check("arst busy", {63'd0, Busy}, 64'd0);
    check("arst done", {63'd0, Done}, 64'd0);
    check("arst hi", {32'd0, Hi}, 64'd0);
    check("arst lo", {32'd0, Lo}, 64'd0);
    #2 Rst = 1'b1;
    tick();
    m_hi = 32'd0; m_lo = 32'd0;
    apply(4'd8, 32'd5, 32'd0, 32'd5, 32'd0, 0, "mthi after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
